rop_bperm_seq: RTL and testbench
================================

# rop_bperm_seq

Multi-cycle byte-permute sequencer that drives the read and write ports of the byte-addressable general-purpose register file. It accepts one request at a time, fetches two source words, and writes a permuted result into a destination register, one byte at a time. It is the initiator for the register file's A/B read ports and C write port. It sits between instruction decode and the register file for byte-shuffle operations.

## Interface
Parameters: none.

Ports:
- clk  in  1  global clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block is idle and can accept a request
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_rd  in  5  destination register
- req_sel  in  12  four 3-bit selectors; sel[3i+2:3i] picks result byte i; 0-3 select rs1 bytes 0-3, 4-7 select rs2 bytes 0-3
- rsp_done  out  1  single-cycle pulse; the final write commits at the end of this cycle
- a_reg_addr, b_reg_addr  out  5 each  register-file read addresses
- a_byte, b_byte  out  1 each  held at the register-file encoding for a full-word read
- a_byte_addr, b_byte_addr  out  2 each  driven to 0
- a_rdata, b_rdata  in  32 each  combinational read data returned by the register file
- c_wen  out  1  write enable
- c_reg_addr  out  5  write register
- c_byte  out  1  1 = write a single byte, 0 = write the whole word
- c_byte_addr  out  2  byte lane for a byte write
- c_wdata  out  32  LSB-aligned write data

## Operation
- Captured on accept: rs1, rs2, rd, sel. Source data is captured as a 64-bit buffer {rs2 word, rs1 word}.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture the request and go to FETCH.
  - FETCH: drive a_reg_addr=rs1 and b_reg_addr=rs2. Latch a_rdata/b_rdata into the buffer at the clock edge. Go to WR0.
  - WR0..WR3: c_wen=1, c_byte=1, c_byte_addr=i, c_reg_addr=rd, c_wdata={24'b0, buf byte sel_i}. Go to WR(i+1).
  - After WR3, return to IDLE. rsp_done=1 during WR3.
- Source aliasing: both sources are fully buffered before any write, so rd==rs1 or rd==rs2 gives a correct permutation of the original values.
- rd==0: all four writes are still issued. The register file discards them.
- req_valid while busy: ignored (req_ready=0). A request is never dropped without handshake.
- Output defaults outside their active states:
  - c_wen=0
  - all address outputs 0
  - c_wdata 0
  - a_byte/b_byte at word-read encoding
- Reset (asynchronous, including mid-operation): state goes to IDLE and captured fields clear to 0.
  - A partially written rd is left as-is; no rollback.
  - Reset values: req_ready=1, rsp_done=0, c_wen=0, all addresses 0, c_wdata 0, c_byte 0.

## Timing
- Accept edge is T0. FETCH occupies cycle T1. WR0..WR3 occupy T2..T5. rsp_done is high in T5. IDLE (req_ready=1) returns at T6.
- Throughput: one request per 6 cycles. A new request may be accepted in the first cycle req_ready is high again.
- Register-file writes commit at the rising edge ending each WR cycle.
- All outputs are registered state or decoded only from state and captured fields. There are no combinational paths from req_* to register-file ports.

## Configuration
- Macro: ROP_BPERM_WORD_WRITE_EN.
- Defined: WR0..WR3 are replaced by a single WR state.
  - c_byte=0.
  - c_wdata = {byte sel3, byte sel2, byte sel1, byte sel0}.
  - rsp_done is high in T2; IDLE returns at T3; throughput is one request per 3 cycles.
- Undefined: the four byte-write sequence described above.
- Functional result in rd is identical in both builds.

## Test plan
- Identity permutation: rs1=x5=0x44332211, rs2=x6=0xDDCCBBAA, sel={3'd3,3'd2,3'd1,3'd0}, rd=x7 -> x7=0x44332211; rsp_done at T5; four byte writes to lanes 0,1,2,3 in order.
- Cross-source permutation: same sources, sel={3'd4,3'd0,3'd7,3'd1}, rd=x7 -> x7=0xAA11DD22.
- Aliasing: rd=rs1=x5=0x44332211, sel={3'd0,3'd1,3'd2,3'd3} -> x5=0x11223344 (byte reverse). No corruption from partial writes.
- Back-pressure: hold req_valid high with a second request during T1..T5 -> req_ready=0 and the request is not captured. It is accepted at T6, and its rsp_done occurs at T11.
- Reset mid-operation: deassert resetn during WR1 -> c_wen drops immediately and req_ready=1. rd holds only the byte-0 update. A subsequent request completes normally.
- With ROP_BPERM_WORD_WRITE_EN: identity case -> a single write with c_byte=0 and c_wdata=0x44332211 in T2, and rsp_done in T2.

Source files
------------

// File: rtl/rop_bperm_seq.sv
// rop_bperm_seq: multi-cycle byte-permute sequencer driving the register file
// A/B read ports and C write port. Reads rs1/rs2 into a 64-bit buffer, then
// writes the permuted result into rd.
// Build option: ROP_BPERM_WORD_WRITE_EN replaces the four byte writes with a
// single whole-word write.
module rop_bperm_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic [11:0] req_sel,
    output logic        rsp_done,
    output logic [4:0]  a_reg_addr,
    output logic [4:0]  b_reg_addr,
    output logic        a_byte,
    output logic        b_byte,
    output logic [1:0]  a_byte_addr,
    output logic [1:0]  b_byte_addr,
    input  logic [31:0] a_rdata,
    input  logic [31:0] b_rdata,
    output logic        c_wen,
    output logic [4:0]  c_reg_addr,
    output logic        c_byte,
    output logic [1:0]  c_byte_addr,
    output logic [31:0] c_wdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
`ifdef ROP_BPERM_WORD_WRITE_EN
    localparam logic [2:0] ST_WR    = 3'd2;
`else
    localparam logic [2:0] ST_WR0   = 3'd2;
    localparam logic [2:0] ST_WR1   = 3'd3;
    localparam logic [2:0] ST_WR2   = 3'd4;
    localparam logic [2:0] ST_WR3   = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] sel_q, sel_d;
    logic [63:0] buf_q, buf_d;

    // Selects one byte of the {rs2, rs1} buffer; 0-3 are rs1 bytes, 4-7 rs2 bytes.
    function automatic logic [7:0] pick(input logic [63:0] b, input logic [2:0] s);
        return b[{s, 3'b000} +: 8];
    endfunction

    // Next-state and request capture.
    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    rd_d    = req_rd;
                    sel_d   = req_sel;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                buf_d = {b_rdata, a_rdata};
`ifdef ROP_BPERM_WORD_WRITE_EN
                state_d = ST_WR;
`else
                state_d = ST_WR0;
`endif
            end
`ifdef ROP_BPERM_WORD_WRITE_EN
            ST_WR:  state_d = ST_IDLE;
`else
            ST_WR0: state_d = ST_WR1;
            ST_WR1: state_d = ST_WR2;
            ST_WR2: state_d = ST_WR3;
            ST_WR3: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured fields; asynchronous reset returns to idle and clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            sel_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
            buf_q   <= buf_d;
        end
    end

    // Read-port controls are constant: always a full-word read.
    assign a_byte      = 1'b0;
    assign b_byte      = 1'b0;
    assign a_byte_addr = '0;
    assign b_byte_addr = '0;

    // Port outputs decoded only from state and captured fields.
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        rsp_done    = 1'b0;
        a_reg_addr  = '0;
        b_reg_addr  = '0;
        c_wen       = 1'b0;
        c_reg_addr  = '0;
        c_byte      = 1'b0;
        c_byte_addr = '0;
        c_wdata     = '0;
        case (state_q)
            ST_FETCH: begin
                a_reg_addr = rs1_q;
                b_reg_addr = rs2_q;
            end
`ifdef ROP_BPERM_WORD_WRITE_EN
            ST_WR: begin
                c_wen      = 1'b1;
                c_reg_addr = rd_q;
                c_wdata    = {pick(buf_q, sel_q[11:9]), pick(buf_q, sel_q[8:6]),
                              pick(buf_q, sel_q[5:3]),  pick(buf_q, sel_q[2:0])};
                rsp_done   = 1'b1;
            end
`else
            ST_WR0, ST_WR1, ST_WR2, ST_WR3: begin
                c_wen      = 1'b1;
                c_byte     = 1'b1;
                c_reg_addr = rd_q;
                case (state_q)
                    ST_WR0: begin
                        c_byte_addr = 2'd0;
                        c_wdata     = {24'b0, pick(buf_q, sel_q[2:0])};
                    end
                    ST_WR1: begin
                        c_byte_addr = 2'd1;
                        c_wdata     = {24'b0, pick(buf_q, sel_q[5:3])};
                    end
                    ST_WR2: begin
                        c_byte_addr = 2'd2;
                        c_wdata     = {24'b0, pick(buf_q, sel_q[8:6])};
                    end
                    default: begin
                        c_byte_addr = 2'd3;
                        c_wdata     = {24'b0, pick(buf_q, sel_q[11:9])};
                        rsp_done    = 1'b1;
                    end
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rop_bperm_seq.sv
// Directed bench for rop_bperm_seq with a behavioural register file model.
// Honours ROP_BPERM_WORD_WRITE_EN for the single-write build.
module tb_rop_bperm_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic [11:0] req_sel;
    logic        rsp_done;
    logic [4:0]  a_reg_addr, b_reg_addr;
    logic        a_byte, b_byte;
    logic [1:0]  a_byte_addr, b_byte_addr;
    logic [31:0] a_rdata, b_rdata;
    logic        c_wen;
    logic [4:0]  c_reg_addr;
    logic        c_byte;
    logic [1:0]  c_byte_addr;
    logic [31:0] c_wdata;

    int errors = 0;
    int checks = 0;

    // Register file model: combinational reads, writes at the rising edge, x0 discards.
    logic [31:0] rf [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            rf[pre_addr] <= pre_data;
        end else if (c_wen && c_reg_addr != 5'd0) begin
            if (c_byte) rf[c_reg_addr][{c_byte_addr, 3'b000} +: 8] <= c_wdata[7:0];
            else        rf[c_reg_addr] <= c_wdata;
        end
    end

    assign a_rdata = rf[a_reg_addr];
    assign b_rdata = rf[b_reg_addr];

    rop_bperm_seq dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_sel(req_sel),
        .rsp_done(rsp_done),
        .a_reg_addr(a_reg_addr), .b_reg_addr(b_reg_addr),
        .a_byte(a_byte), .b_byte(b_byte),
        .a_byte_addr(a_byte_addr), .b_byte_addr(b_byte_addr),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .c_wen(c_wen), .c_reg_addr(c_reg_addr), .c_byte(c_byte),
        .c_byte_addr(c_byte_addr), .c_wdata(c_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_en   = 1'b0;
    endtask

    // Presents a request, confirms it is takeable, and clocks the accept edge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [11:0] sel);
        req_valid = 1'b1;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_sel   = sel;
        chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
        tick();
    endtask

    // Walks FETCH and the write cycles following an accept edge, then checks rd.
    task automatic run_ops(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] exp_word,
                           input logic [31:0] exp_rf);
        chk({tag, "_fetch_a"}, {27'b0, a_reg_addr}, {27'b0, rs1});
        chk({tag, "_fetch_b"}, {27'b0, b_reg_addr}, {27'b0, rs2});
        chk({tag, "_fetch_wen"}, {31'b0, c_wen}, 32'd0);
        chk({tag, "_fetch_ready"}, {31'b0, req_ready}, 32'd0);
        tick();
`ifdef ROP_BPERM_WORD_WRITE_EN
        chk({tag, "_wr_wen"}, {31'b0, c_wen}, 32'd1);
        chk({tag, "_wr_byte"}, {31'b0, c_byte}, 32'd0);
        chk({tag, "_wr_rd"}, {27'b0, c_reg_addr}, {27'b0, rd});
        chk({tag, "_wr_data"}, c_wdata, exp_word);
        chk({tag, "_wr_done"}, {31'b0, rsp_done}, 32'd1);
        tick();
`else
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_wr_wen"}, {31'b0, c_wen}, 32'd1);
            chk({tag, "_wr_byte"}, {31'b0, c_byte}, 32'd1);
            chk({tag, "_wr_lane"}, {30'b0, c_byte_addr}, i);
            chk({tag, "_wr_rd"}, {27'b0, c_reg_addr}, {27'b0, rd});
            chk({tag, "_wr_data"}, c_wdata, {24'b0, exp_word[8*i +: 8]});
            chk({tag, "_wr_done"}, {31'b0, rsp_done}, (i == 3) ? 32'd1 : 32'd0);
            chk({tag, "_wr_ready"}, {31'b0, req_ready}, 32'd0);
            tick();
        end
`endif
        chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_idle_done"}, {31'b0, rsp_done}, 32'd0);
        chk({tag, "_idle_wen"}, {31'b0, c_wen}, 32'd0);
        chk({tag, "_idle_wdata"}, c_wdata, 32'd0);
        chk({tag, "_rf"}, rf[rd], exp_rf);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_rd    = '0;
        req_sel   = '0;
        #2;
        // Reset values
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_done", {31'b0, rsp_done}, 32'd0);
        chk("rst_wen", {31'b0, c_wen}, 32'd0);
        chk("rst_addrs", {a_reg_addr, b_reg_addr, c_reg_addr, c_byte_addr}, 32'd0);
        chk("rst_wdata", c_wdata, 32'd0);
        chk("rst_cbyte", {31'b0, c_byte}, 32'd0);
        chk("rst_rbyte", {28'b0, a_byte, b_byte, a_byte_addr[0], b_byte_addr[0]}, 32'd0);

        preload(5'd0, 32'h0000_0000);
        preload(5'd5, 32'h4433_2211);
        preload(5'd6, 32'hDDCC_BBAA);
        preload(5'd10, 32'h0000_0000);
        resetn = 1'b1;
        tick();

        // Identity permutation
        issue(5'd5, 5'd6, 5'd7, {3'd3, 3'd2, 3'd1, 3'd0});
        req_valid = 1'b0;
        run_ops("ident", 5'd5, 5'd6, 5'd7, 32'h4433_2211, 32'h4433_2211);

        // Cross-source permutation, accepted in the first ready cycle
        issue(5'd5, 5'd6, 5'd7, {3'd4, 3'd0, 3'd7, 3'd1});
        req_valid = 1'b0;
        run_ops("cross", 5'd5, 5'd6, 5'd7, 32'hAA11_DD22, 32'hAA11_DD22);

        // rd aliases rs1: byte reverse of original x5
        issue(5'd5, 5'd6, 5'd5, {3'd0, 3'd1, 3'd2, 3'd3});
        req_valid = 1'b0;
        run_ops("alias", 5'd5, 5'd6, 5'd5, 32'h1122_3344, 32'h1122_3344);

        // rd = x0: writes still issued, register file keeps zero
        issue(5'd6, 5'd5, 5'd0, {3'd3, 3'd2, 3'd1, 3'd0});
        req_valid = 1'b0;
        run_ops("rd0", 5'd6, 5'd5, 5'd0, 32'hDDCC_BBAA, 32'h0000_0000);

        // Back-pressure: second request held valid while the first runs
        issue(5'd6, 5'd5, 5'd8, {3'd3, 3'd2, 3'd1, 3'd0});
        req_rs1 = 5'd5;
        req_rs2 = 5'd6;
        req_rd  = 5'd9;
        req_sel = {3'd4, 3'd5, 3'd6, 3'd7};
        run_ops("bp_first", 5'd6, 5'd5, 5'd8, 32'hDDCC_BBAA, 32'hDDCC_BBAA);
        issue(5'd5, 5'd6, 5'd9, {3'd4, 3'd5, 3'd6, 3'd7});
        req_valid = 1'b0;
        run_ops("bp_second", 5'd5, 5'd6, 5'd9, 32'hAABB_CCDD, 32'hAABB_CCDD);

        // Reset in the middle of an operation
        issue(5'd6, 5'd5, 5'd10, {3'd3, 3'd2, 3'd1, 3'd0});
        req_valid = 1'b0;
`ifndef ROP_BPERM_WORD_WRITE_EN
        tick();
        chk("mid_wr0_wen", {31'b0, c_wen}, 32'd1);
        tick();
        chk("mid_wr1_lane", {30'b0, c_byte_addr}, 32'd1);
`endif
        resetn = 1'b0;
        #1;
        chk("mid_rst_wen", {31'b0, c_wen}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_done", {31'b0, rsp_done}, 32'd0);
        chk("mid_rst_wdata", c_wdata, 32'd0);
        chk("mid_rst_caddr", {27'b0, c_reg_addr}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
`ifdef ROP_BPERM_WORD_WRITE_EN
        chk("mid_rst_rf", rf[10], 32'h0000_0000);
`else
        chk("mid_rst_rf", rf[10], 32'h0000_00AA);
`endif
        issue(5'd5, 5'd6, 5'd10, {3'd3, 3'd2, 3'd1, 3'd0});
        req_valid = 1'b0;
        run_ops("post_rst", 5'd5, 5'd6, 5'd10, 32'h1122_3344, 32'h1122_3344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
